mem_access_ctrl: RTL and testbench

//   Sequences the shared off-chip 16-bit SRAM on behalf of the pipeline's memory stage.

---
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller for a shared 16-bit SRAM.
// A 32-bit access is run as two timed halfword phases, and the pipeline is frozen until it finishes.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        freeze,
  output logic        err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_ce_n
);

  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);
  localparam logic [31:0] SPAN     = 32'h0008_0000;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t      r_state, w_nxt_state;
  logic [3:0]  r_cnt, w_nxt_cnt;
  logic        r_op_wr;
  logic [31:0] r_wdata;
  logic [16:0] r_hw_base;

  logic        w_req, w_accept, w_in_range, w_last, w_phase;
  logic        w_op_wr;
  logic [31:0] w_off, w_wdata;
  logic [16:0] w_hw_base;
  logic        w_nxt_we_n, w_nxt_oe, w_nxt_ce_n;
  logic [17:0] w_nxt_addr;
  logic [15:0] w_nxt_dq;

  assign w_req      = mem_r_en | mem_w_en;
  assign w_accept   = (r_state == S_IDLE) && w_req;
  assign w_off      = addr - BASE;
  assign w_in_range = (addr >= BASE) && (w_off < SPAN);
  assign w_last     = (r_cnt == LAST_CNT);
  assign freeze     = w_req & ~ready;

  // Operands come straight from the request in the accept cycle, from the latches afterwards.
  assign w_op_wr   = (r_state == S_IDLE) ? mem_w_en     : r_op_wr;
  assign w_wdata   = (r_state == S_IDLE) ? wr_data      : r_wdata;
  assign w_hw_base = (r_state == S_IDLE) ? w_off[18:2]  : r_hw_base;

  // Next-state and phase counter.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_nxt_state = w_in_range ? S_LOW : S_DONE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_nxt_state = S_HIGH;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt   = r_cnt + 4'd1;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_nxt_state = S_DONE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt   = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 4'd0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, so the pins themselves can be registered.
  always_comb begin
    w_phase    = (w_nxt_state == S_LOW) || (w_nxt_state == S_HIGH);
    w_nxt_ce_n = ~w_phase;
    w_nxt_oe   = w_phase & w_op_wr;
    w_nxt_we_n = ~(w_phase & w_op_wr & (w_nxt_cnt != LAST_CNT));
    if (w_phase) begin
      w_nxt_addr = {w_hw_base, (w_nxt_state == S_HIGH)};
    end else begin
      w_nxt_addr = sram_addr;
    end
    if (w_nxt_state == S_LOW) begin
      w_nxt_dq = w_wdata[15:0];
    end else if (w_nxt_state == S_HIGH) begin
      w_nxt_dq = w_wdata[31:16];
    end else begin
      w_nxt_dq = sram_dq_out;
    end
  end

  // State, request latches, read capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_op_wr     <= 1'b0;
      r_wdata     <= 32'd0;
      r_hw_base   <= 17'd0;
      rd_data     <= 32'd0;
      ready       <= 1'b0;
      err         <= 1'b0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      ready       <= (w_nxt_state == S_DONE);
      sram_addr   <= w_nxt_addr;
      sram_dq_out <= w_nxt_dq;
      sram_dq_oe  <= w_nxt_oe;
      sram_we_n   <= w_nxt_we_n;
      sram_ce_n   <= w_nxt_ce_n;
      if (w_accept) begin
        r_op_wr   <= mem_w_en;
        r_wdata   <= wr_data;
        r_hw_base <= w_off[18:2];
      end
      if (w_accept && (!w_in_range || (mem_r_en && mem_w_en))) begin
        err <= 1'b1;
      end
      if (w_accept && !w_in_range) begin
        rd_data <= 32'd0;
      end else if ((r_state == S_LOW) && w_last && !r_op_wr) begin
        rd_data[15:0] <= sram_dq_in;
      end else if ((r_state == S_HIGH) && w_last && !r_op_wr) begin
        rd_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small behavioural SRAM.
module tb_mem_access_ctrl;
  localparam int W    = 5;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wr_data, rd_data;
  logic        ready, freeze, err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_ce_n;

  logic [15:0] mem [0:63];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .freeze(freeze), .err(err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
    .sram_ce_n(sram_ce_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[5:0]];

  // SRAM model: preload port for the bench, otherwise write when selected, strobed and driven.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present a request at #1 after a rising edge, watch it until ready, then drop it.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int rdy_cyc, output int frz, output int ce_low,
                            output int we_low, output int oe_cnt,
                            output logic [17:0] a_lo, output logic [17:0] a_hi);
    mem_r_en = r; mem_w_en = w; addr = a; wr_data = d;
    rdy_cyc = -1; frz = 0; ce_low = 0; we_low = 0; oe_cnt = 0; a_lo = '0; a_hi = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (freeze) frz++;
      if (!sram_ce_n) ce_low++;
      if (!sram_we_n) we_low++;
      if (sram_dq_oe) oe_cnt++;
      if (c == 1) a_lo = sram_addr;
      if (c == W + 1) a_hi = sram_addr;
      if (ready) begin
        rdy_cyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  initial begin
    int rc, fz, cl, wl, oc, rc2, bad;
    logic [17:0] alo, ahi;

    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wr_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // 1: preload under reset, release, idle for 20 cycles
    @(posedge clk); #1; ld_en = 1'b1; ld_addr = 6'd4; ld_data = 16'h5678;
    @(posedge clk); #1; ld_addr = 6'd5; ld_data = 16'h1234;
    @(posedge clk); #1; ld_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    check_val("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check_val("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check_val("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_val("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check_val("rst_freeze", {31'd0, freeze}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_ce_n || freeze || ready) bad++;
    end
    check_val("idle_20_cycles", bad, 0);
    @(posedge clk); #1;

    // 2: read hw4/hw5
    run_access(1'b1, 1'b0, BASE + 8, 32'd0, rc, fz, cl, wl, oc, alo, ahi);
    check_val("rd_ready_cycle", rc, 11);
    check_val("rd_freeze_cycles", fz, 11);
    check_val("rd_ce_low", cl, 10);
    check_val("rd_we_low", wl, 0);
    check_val("rd_oe", oc, 0);
    check_val("rd_addr_lo", {14'd0, alo}, 32'd4);
    check_val("rd_addr_hi", {14'd0, ahi}, 32'd5);
    check_val("rd_data", rd_data, 32'h12345678);
    check_val("rd_err", {31'd0, err}, 32'd0);

    // 3: write hw6/hw7
    run_access(1'b0, 1'b1, BASE + 12, 32'hDEADBEEF, rc, fz, cl, wl, oc, alo, ahi);
    check_val("wr_ready_cycle", rc, 11);
    check_val("wr_we_low", wl, 8);
    check_val("wr_oe", oc, 10);
    check_val("wr_addr_lo", {14'd0, alo}, 32'd6);
    check_val("wr_addr_hi", {14'd0, ahi}, 32'd7);
    check_val("wr_hw6", {16'd0, mem[6]}, 32'h0000BEEF);
    check_val("wr_hw7", {16'd0, mem[7]}, 32'h0000DEAD);
    check_val("wr_rd_data_held", rd_data, 32'h12345678);

    // 4: write then read the same word back-to-back
    run_access(1'b0, 1'b1, BASE + 20, 32'hDEADBEEF, rc, fz, cl, wl, oc, alo, ahi);
    run_access(1'b1, 1'b0, BASE + 20, 32'd0, rc2, fz, cl, wl, oc, alo, ahi);
    check_val("b2b_second_ready", rc + 1 + rc2, 23);
    check_val("b2b_rd_data", rd_data, 32'hDEADBEEF);
    check_val("b2b_err", {31'd0, err}, 32'd0);

    // both enables: performed as a write and flagged
    run_access(1'b1, 1'b1, BASE + 24, 32'hCAFEF00D, rc, fz, cl, wl, oc, alo, ahi);
    check_val("both_ready_cycle", rc, 11);
    check_val("both_we_low", wl, 8);
    check_val("both_hw12", {16'd0, mem[12]}, 32'h0000F00D);
    check_val("both_hw13", {16'd0, mem[13]}, 32'h0000CAFE);
    check_val("both_err", {31'd0, err}, 32'd1);

    // 6: reset in cycle 3 of a write
    mem_w_en = 1'b1; mem_r_en = 1'b0; addr = BASE + 28; wr_data = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_we_before", {31'd0, sram_we_n}, 32'd0);
    #1; rst = 1'b0;
    #1;
    check_val("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check_val("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check_val("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check_val("abort_ready", {31'd0, ready}, 32'd0);
    mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ready || !sram_ce_n) bad++;
    end
    check_val("abort_no_ready", bad, 0);
    check_val("abort_err_cleared", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, BASE + 8, 32'd0, rc, fz, cl, wl, oc, alo, ahi);
    check_val("post_abort_ready", rc, 11);
    check_val("post_abort_rd", rd_data, 32'h12345678);

    // 5: below base -> immediate completion with error, no SRAM activity
    run_access(1'b1, 1'b0, 32'd16, 32'd0, rc, fz, cl, wl, oc, alo, ahi);
    check_val("oor_ready_cycle", rc, 1);
    check_val("oor_freeze_cycles", fz, 1);
    check_val("oor_ce_low", cl, 0);
    check_val("oor_rd_data", rd_data, 32'd0);
    check_val("oor_err", {31'd0, err}, 32'd1);
    run_access(1'b1, 1'b0, BASE + 8, 32'd0, rc, fz, cl, wl, oc, alo, ahi);
    check_val("oor_err_sticky", {31'd0, err}, 32'd1);
    check_val("oor_then_rd", rd_data, 32'h12345678);

    // above the 2^19-byte window
    run_access(1'b0, 1'b1, BASE + 32'h0008_0000, 32'h0, rc, fz, cl, wl, oc, alo, ahi);
    check_val("oor_high_ready", rc, 1);
    check_val("oor_high_ce_low", cl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
